// File: rtl/unpacked_serializer.sv
// Width-down converter: takes one IN_NUM-element vector per handshake and replays it
// as IN_NUM/OUT_NUM consecutive OUT_NUM-element chunks, lowest element indices first.
module unpacked_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 8,
    parameter int OUT_NUM    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0],
    output logic                  data_out_valid,
    output logic                  data_out_last,
    input  logic                  data_out_ready
);

    localparam int RATIO = IN_NUM / OUT_NUM;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (IN_NUM % OUT_NUM != 0) begin : g_bad_ratio
        $error("unpacked_serializer: IN_NUM must be a multiple of OUT_NUM");
    end

    logic [DATA_WIDTH-1:0] vec_q [IN_NUM-1:0];
    logic                  full_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] chunk [RATIO-1:0][OUT_NUM-1:0];
    logic                  in_fire;
    logic                  out_fire;

    // Static view of the held vector as RATIO chunks; the counter picks one.
    for (genvar c = 0; c < RATIO; c++) begin : g_chunk
        for (genvar j = 0; j < OUT_NUM; j++) begin : g_elem
            assign chunk[c][j] = vec_q[c*OUT_NUM + j];
        end
    end

    assign data_out       = chunk[cnt_q];
    assign data_out_valid = full_q;
    assign data_out_last  = full_q && (cnt_q == CNT_W'(RATIO - 1));
    // Refill is allowed while the last chunk leaves, so vectors stream without a bubble.
    assign data_in_ready  = !full_q || (data_out_last && data_out_ready);
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = data_out_valid && data_out_ready;

    // NOTE: every register here is updated with <= so all state advances from
    // the same pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            cnt_q  <= '0;
            // NOTE: the vector register is reset (not just the valid flag) because
            // data_out is a direct view of it and must read zero after reset.
            vec_q  <= '{default: '0};
        end else if (in_fire) begin
            vec_q  <= data_in;
            cnt_q  <= '0;
            full_q <= 1'b1;
        end else if (out_fire) begin
            if (data_out_last) begin
                full_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
